// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU slice.
// One operation is in flight at a time. The operands are registered for one
// EXEC cycle. The result and flags are then held on a valid/ready response
// channel.
module alu_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             tag_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       op_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [2:0]       rsp_flags_q;
  logic             busy_q;

  logic window, grant, accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A response drained in the same cycle as a new accept
  // goes straight back to EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: accept window, round-robin grant and the ready strobes.
  // A tie goes to the requester that did not win last time. The readies are
  // gated by rst_n so that nothing is accepted while reset is held.
  always_comb begin
    window = (state_q == IDLE) || (state_q == RESP && rsp_ready);
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
    req0_ready = rst_n && window && !grant && req0_valid;
    req1_ready = rst_n && window &&  grant && req1_valid;
    accept     = req0_ready || req1_ready;
  end

  // Operand/tag capture at accept, and response capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      tag_q        <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (accept) begin
        last_grant_q <= req1_ready;
        tag_q        <= req1_ready;
        opa_q        <= req1_ready ? req1_a  : req0_a;
        opb_q        <= req1_ready ? req1_b  : req0_b;
        op_q         <= req1_ready ? req1_op : req0_op;
      end
      if (state_q == EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= tag_q;
        rsp_result_q <= alu_result;
        rsp_flags_q  <= {alu_zero, alu_carry, alu_negative};
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;

endmodule
